// File: rtl/mealy_seq_detector_if.sv
// rtl/mealy_seq_detector_if.sv - symbol stream, pattern load and match result bundle
interface mealy_seq_detector_if #(
  parameter int DATA_W  = 4,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 16
);
  localparam int K_W = $clog2(SEQ_LEN);

  logic                      valid_i;
  logic [DATA_W-1:0]         data_i;
  logic                      overlap_i;
  logic                      load_i;
  logic [SEQ_LEN*DATA_W-1:0] pattern_i;
  logic                      match_o;
  logic [K_W-1:0]            state_o;
  logic [CNT_W-1:0]          match_cnt_o;

  modport master (
    output valid_i, data_i, overlap_i, load_i, pattern_i,
    input  match_o, state_o, match_cnt_o
  );

  modport slave (
    input  valid_i, data_i, overlap_i, load_i, pattern_i,
    output match_o, state_o, match_cnt_o
  );
endinterface

// File: rtl/mealy_seq_detector.sv
// rtl/mealy_seq_detector.sv - programmable Mealy pattern detector over a symbol stream
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module mealy_seq_detector #(
  parameter int                        DATA_W        = 4,
  parameter int                        SEQ_LEN       = 4,
  parameter logic [SEQ_LEN*DATA_W-1:0] RESET_PATTERN = {4'd9, 4'd3, 4'd2, 4'd1},
  parameter int                        CNT_W         = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  mealy_seq_detector_if.slave bus
);
  localparam int             K_W    = $clog2(SEQ_LEN);
  localparam logic [K_W-1:0] K_LAST = K_W'(SEQ_LEN - 1);

  logic [SEQ_LEN*DATA_W-1:0] pat_q, pat_d;
  logic [K_W-1:0]            k_q, k_d, k_adv;
  logic [DATA_W-1:0]         sym [SEQ_LEN];
  logic                      accept;
  logic                      match;
  logic                      ok;

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_sym
    assign sym[g] = pat_q[g*DATA_W +: DATA_W];
  end

  assign accept = bus.valid_i & ~bus.load_i & ~rst_i;
  assign match  = accept & (k_q == K_LAST) & (bus.data_i == sym[SEQ_LEN-1]);

  // Failure function evaluated on the fly: prefix j survives when its last symbol
  // equals data_i and its first j-1 symbols equal the tail of the current prefix k.
  always_comb begin
    k_adv = '0;
    ok    = 1'b0;
    for (int j = 1; j < SEQ_LEN; j++) begin
      ok = (j <= int'(k_q) + 1) && (sym[K_W'(j - 1)] == bus.data_i);
      for (int m = 0; m < SEQ_LEN - 2; m++) begin
        if (ok && (m < j - 1) && (sym[K_W'(m)] != sym[K_W'(int'(k_q) - j + 1 + m)])) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        k_adv = K_W'(j);
      end
    end
  end

  always_comb begin
    pat_d = pat_q;
    k_d   = k_q;
    if (bus.load_i) begin
      pat_d = bus.pattern_i;
      k_d   = '0;
    end else if (bus.valid_i) begin
      k_d = (match && !bus.overlap_i) ? '0 : k_adv;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q   <= '0;
      pat_q <= RESET_PATTERN;
    end else begin
      k_q   <= k_d;
      pat_q <= pat_d;
    end
  end

  assign bus.match_o = match;
  assign bus.state_o = k_q;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_cnt_o = cnt_q;
`else
  assign bus.match_cnt_o = '0;
`endif
endmodule
